// File: rtl/game_state_ctrl.sv
// Frame-rate game state register for the breakout core: latches the collision
// stage results during play and sequences serve / lost / clear / game-over.
module game_state_ctrl #(
    parameter int H_BALL0     = 312,
    parameter int BALL_W      = 16,
    parameter int BALL_H      = 10,
    parameter int BOARD_Y     = 467,
    parameter int LOSE_Y      = 478,
    parameter int VX0         = 4,
    parameter int VY0         = 4,
    parameter int LIVES0      = 3,
    parameter int LOST_FRAMES = 60,
    parameter logic [1439:0] BRICK_INIT = {240{6'b010_011}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_tick,
    input  logic          launch,
    input  logic [9:0]    board_x,
    input  logic [1439:0] nxt_bricks,
    input  logic [9:0]    nxt_ball_x,
    input  logic [9:0]    nxt_ball_y,
    input  logic [9:0]    nxt_ball_vx,
    input  logic [9:0]    nxt_ball_vy,
    input  logic [1:0]    nxt_ball_dir,
    input  logic          nxt_collision,
    output logic [1439:0] bricks,
    output logic [9:0]    ball_x,
    output logic [9:0]    ball_y,
    output logic [9:0]    ball_vx,
    output logic [9:0]    ball_vy,
    output logic [1:0]    ball_dir,
    output logic [1:0]    lives,
    output logic [15:0]   score,
    output logic [2:0]    state,
    output logic          sfx_pulse
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_LOST  = 3'd2,
        S_CLEAR = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(LOST_FRAMES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOST_FRAMES - 1);
    localparam logic [9:0]  PARK_Y   = 10'(BOARD_Y - BALL_H - 1);
    localparam logic [9:0]  PARK_DX  = 10'((96 - BALL_W) / 2);
    localparam logic [9:0]  X_RST    = 10'(H_BALL0);
    localparam logic [9:0]  VX_RST   = 10'(VX0);
    localparam logic [9:0]  VY_RST   = 10'(VY0);
    localparam logic [1:0]  DIR_RST  = 2'b10;
    localparam logic [1:0]  LIVES_RST = 2'(LIVES0);
    localparam logic [10:0] LOSE_LIM = 11'(LOSE_Y);
    localparam logic [10:0] BALL_H11 = 11'(BALL_H);

    state_t          st, st_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [1439:0]   bricks_d;
    logic [9:0]      x_d, y_d, vx_d, vy_d;
    logic [1:0]      dir_d, lives_d;
    logic [15:0]     score_d;
    logic            sfx_d;

    logic [9:0]  park_x;
    logic [10:0] ball_bottom;
    logic        lose_hit;
    logic        bricks_empty;
    logic        bricks_changed;

    // 10-bit wrap gives the same result as an 11-bit add truncated to 10 bits
    assign park_x         = board_x + PARK_DX;
    assign ball_bottom    = {1'b0, nxt_ball_y} + BALL_H11;
    assign lose_hit       = (ball_bottom >= LOSE_LIM);
    assign bricks_empty   = (nxt_bricks == '0);
    assign bricks_changed = (nxt_bricks != bricks);
    assign state          = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_IDLE;
            cnt       <= '0;
            bricks    <= BRICK_INIT;
            ball_x    <= X_RST;
            ball_y    <= PARK_Y;
            ball_vx   <= VX_RST;
            ball_vy   <= VY_RST;
            ball_dir  <= DIR_RST;
            lives     <= LIVES_RST;
            score     <= '0;
            sfx_pulse <= 1'b0;
        end else begin
            st        <= st_d;
            cnt       <= cnt_d;
            bricks    <= bricks_d;
            ball_x    <= x_d;
            ball_y    <= y_d;
            ball_vx   <= vx_d;
            ball_vy   <= vy_d;
            ball_dir  <= dir_d;
            lives     <= lives_d;
            score     <= score_d;
            sfx_pulse <= sfx_d;
        end
    end

    always_comb begin
        st_d     = st;
        cnt_d    = cnt;
        bricks_d = bricks;
        x_d      = ball_x;
        y_d      = ball_y;
        vx_d     = ball_vx;
        vy_d     = ball_vy;
        dir_d    = ball_dir;
        lives_d  = lives;
        score_d  = score;
        sfx_d    = 1'b0;

        case (st)
            S_IDLE: begin
                // launch wins over a same-cycle tick, so the ball is not re-parked
                if (launch) begin
                    st_d  = S_PLAY;
                    vx_d  = VX_RST;
                    vy_d  = VY_RST;
                    dir_d = DIR_RST;
                end else if (frame_tick) begin
                    x_d = park_x;
                    y_d = PARK_Y;
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    bricks_d = nxt_bricks;
                    x_d      = nxt_ball_x;
                    y_d      = nxt_ball_y;
                    vx_d     = nxt_ball_vx;
                    vy_d     = nxt_ball_vy;
                    dir_d    = nxt_ball_dir;
                    sfx_d    = nxt_collision;
                    if (bricks_changed && (score != 16'hFFFF))
                        score_d = score + 16'd1;
                    if (bricks_empty) begin
                        st_d = S_CLEAR;
                    end else if (lose_hit) begin
                        st_d  = S_LOST;
                        cnt_d = '0;
                    end
                end
            end
            S_LOST: begin
                if (frame_tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt_d = '0;
                        if (lives <= 2'd1) begin
                            lives_d = 2'd0;
                            st_d    = S_OVER;
                        end else begin
                            lives_d = lives - 2'd1;
                            st_d    = S_IDLE;
                            x_d     = park_x;
                            y_d     = PARK_Y;
                        end
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            S_CLEAR: begin
                if (launch) begin
                    bricks_d = BRICK_INIT;
                    st_d     = S_IDLE;
                    x_d      = park_x;
                    y_d      = PARK_Y;
                end
            end
            S_OVER: begin
                if (launch) begin
                    st_d     = S_IDLE;
                    cnt_d    = '0;
                    bricks_d = BRICK_INIT;
                    x_d      = park_x;
                    y_d      = PARK_Y;
                    vx_d     = VX_RST;
                    vy_d     = VY_RST;
                    dir_d    = DIR_RST;
                    lives_d  = LIVES_RST;
                    score_d  = '0;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Randomized scoreboard bench for game_state_ctrl: a game-rule model predicts
// every post-edge output set; a monitor pops and compares after each clock.
module tb_game_state_ctrl;

    localparam logic [1439:0] INIT = {240{6'b010_011}};

    logic          clk = 1'b0;
    logic          rst_n, frame_tick, launch;
    logic [9:0]    board_x;
    logic [1439:0] nxt_bricks;
    logic [9:0]    nxt_ball_x, nxt_ball_y, nxt_ball_vx, nxt_ball_vy;
    logic [1:0]    nxt_ball_dir;
    logic          nxt_collision;
    logic [1439:0] bricks;
    logic [9:0]    ball_x, ball_y, ball_vx, ball_vy;
    logic [1:0]    ball_dir, lives;
    logic [15:0]   score;
    logic [2:0]    state;
    logic          sfx_pulse;

    always #5 clk = ~clk;

    game_state_ctrl #(.BRICK_INIT(INIT)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .launch(launch),
        .board_x(board_x), .nxt_bricks(nxt_bricks), .nxt_ball_x(nxt_ball_x),
        .nxt_ball_y(nxt_ball_y), .nxt_ball_vx(nxt_ball_vx), .nxt_ball_vy(nxt_ball_vy),
        .nxt_ball_dir(nxt_ball_dir), .nxt_collision(nxt_collision),
        .bricks(bricks), .ball_x(ball_x), .ball_y(ball_y), .ball_vx(ball_vx),
        .ball_vy(ball_vy), .ball_dir(ball_dir), .lives(lives), .score(score),
        .state(state), .sfx_pulse(sfx_pulse)
    );

    typedef struct {
        logic [1439:0] bricks;
        int x, y, vx, vy, dir, lives, score, state, sfx;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Game-rule model: states 0 idle, 1 play, 2 lost, 3 clear, 4 over
    logic [1439:0] m_bricks;
    int m_state, m_x, m_y, m_vx, m_vy, m_dir, m_lives, m_score, m_ticks, m_sfx;

    function automatic int park();
        return (int'(board_x) + 40) % 1024;
    endfunction

    task automatic model_reset();
        m_state = 0; m_bricks = INIT; m_x = 312; m_y = 456;
        m_vx = 4; m_vy = 4; m_dir = 2; m_lives = 3; m_score = 0;
        m_ticks = 0; m_sfx = 0;
    endtask

    task automatic model_edge();
        m_sfx = 0;
        case (m_state)
            0: if (launch) begin
                   m_state = 1; m_vx = 4; m_vy = 4; m_dir = 2;
               end else if (frame_tick) begin
                   m_x = park(); m_y = 456;
               end
            1: if (frame_tick) begin
                   if (nxt_bricks != m_bricks && m_score < 65535) m_score++;
                   m_bricks = nxt_bricks;
                   m_x = int'(nxt_ball_x); m_y = int'(nxt_ball_y);
                   m_vx = int'(nxt_ball_vx); m_vy = int'(nxt_ball_vy);
                   m_dir = int'(nxt_ball_dir); m_sfx = int'(nxt_collision);
                   if (nxt_bricks == '0) m_state = 3;
                   else if (m_y + 10 >= 478) begin m_state = 2; m_ticks = 0; end
               end
            2: if (frame_tick) begin
                   m_ticks++;
                   if (m_ticks == 60) begin
                       m_ticks = 0;
                       m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                       if (m_lives == 0) m_state = 4;
                       else begin m_state = 0; m_x = park(); m_y = 456; end
                   end
               end
            3: if (launch) begin
                   m_bricks = INIT; m_state = 0; m_x = park(); m_y = 456;
               end
            4: if (launch) begin
                   model_reset(); m_x = park();
               end
            default: ;
        endcase
    endtask

    // Drive one clock's inputs (at a negedge), predict, then advance to the next negedge
    task automatic cycle(input bit t, input bit l);
        exp_t e;
        frame_tick = t;
        launch     = l;
        if (!rst_n) model_reset(); else model_edge();
        e.bricks = m_bricks; e.x = m_x; e.y = m_y; e.vx = m_vx; e.vy = m_vy;
        e.dir = m_dir; e.lives = m_lives; e.score = m_score; e.state = m_state; e.sfx = m_sfx;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic set_play(input bit lose);
        nxt_ball_x    = 10'($urandom);
        nxt_ball_vx   = 10'($urandom);
        nxt_ball_vy   = 10'($urandom);
        nxt_ball_dir  = 2'($urandom);
        nxt_collision = 1'($urandom);
        nxt_ball_y    = lose ? 10'($urandom_range(468, 1023)) : 10'($urandom_range(0, 467));
        nxt_bricks    = m_bricks;
        if ($urandom_range(0, 2) == 0) begin
            int c;
            c = $urandom_range(0, 479);
            nxt_bricks[3*c +: 3] = 3'b000;
        end
    endtask

    task automatic lose_life();
        if (m_state == 0) cycle(0, 1);
        set_play(1);
        cycle(1, 0);
        for (int i = 0; i < 60; i++) begin
            set_play($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) cycle(0, $urandom_range(0, 1) == 1);
            cycle(1, $urandom_range(0, 1) == 1);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        logic [63:0] got, want;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            got  = {ball_x, ball_y, ball_vx, ball_vy, ball_dir, lives, score, state, sfx_pulse};
            want = {10'(e.x), 10'(e.y), 10'(e.vx), 10'(e.vy), 2'(e.dir), 2'(e.lives),
                    16'(e.score), 3'(e.state), 1'(e.sfx)};
            n_checks++;
            if (got === want) n_pass++;
            else $display("FAIL regs t=%0t got x=%0d y=%0d vx=%0d vy=%0d dir=%0d lives=%0d score=%0d state=%0d sfx=%0d want x=%0d y=%0d vx=%0d vy=%0d dir=%0d lives=%0d score=%0d state=%0d sfx=%0d",
                          $time, ball_x, ball_y, ball_vx, ball_vy, ball_dir, lives, score, state, sfx_pulse,
                          e.x, e.y, e.vx, e.vy, e.dir, e.lives, e.score, e.state, e.sfx);
            n_checks++;
            if (bricks === e.bricks) n_pass++;
            else $display("FAIL bricks t=%0t got %0d differing bits vs required map (got low=%h want low=%h)",
                          $time, $countones(bricks ^ e.bricks), bricks[63:0], e.bricks[63:0]);
        end
    end

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; launch = 1'b0; board_x = '0;
        nxt_bricks = '0; nxt_ball_x = '0; nxt_ball_y = '0; nxt_ball_vx = '0;
        nxt_ball_vy = '0; nxt_ball_dir = '0; nxt_collision = 1'b0;
        model_reset();

        cycle(0, 0);
        cycle(0, 0);
        rst_n = 1'b1;
        cycle(0, 0);

        // Idle: parking follows board_x on ticks, then launch+tick serves without moving
        for (int i = 0; i < 6; i++) begin
            board_x = 10'($urandom);
            cycle($urandom_range(0, 1) == 1, 0);
        end
        board_x = 10'd200;
        cycle(1, 0);
        cycle(0, 0);
        board_x = 10'd210;
        cycle(1, 1);

        // Play: one brick hit with collision, then random frames
        nxt_bricks = m_bricks; nxt_bricks[5:3] = 3'b000;
        nxt_ball_x = 10'd300; nxt_ball_y = 10'd100; nxt_collision = 1'b1;
        nxt_ball_vx = 10'd5; nxt_ball_vy = 10'd6; nxt_ball_dir = 2'b01;
        cycle(1, 0);
        cycle(0, 0);
        cycle(0, 0);
        for (int i = 0; i < 40; i++) begin
            set_play(0);
            board_x = 10'($urandom);
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end
        set_play(0); nxt_ball_y = 10'd467;
        cycle(1, 0);

        // Lose all three lives, sit in game-over, restart
        for (int l = 0; l < 3; l++) lose_life();
        for (int i = 0; i < 5; i++) begin
            set_play(0);
            cycle(1, 0);
        end
        board_x = 10'd1000;
        cycle(0, 1);

        // Board cleared together with a lost ball: clear wins, launch reloads
        cycle(0, 1);
        for (int i = 0; i < 8; i++) begin
            set_play(0);
            cycle(1, 0);
        end
        nxt_bricks = '0; nxt_ball_y = 10'd470;
        cycle(1, 0);
        set_play(0);
        cycle(1, 0);
        cycle(1, 0);
        board_x = 10'd77;
        cycle(0, 1);

        // Score saturation: every tick flips one cell between two nonzero values
        cycle(0, 1);
        nxt_ball_x = 10'd50; nxt_ball_y = 10'd100; nxt_collision = 1'b0;
        while (m_score < 16'hFFFE) begin
            nxt_bricks = m_bricks;
            nxt_bricks[0] = ~m_bricks[0];
            cycle(1, 0);
        end
        for (int i = 0; i < 3; i++) begin
            nxt_bricks = m_bricks;
            nxt_bricks[0] = ~m_bricks[0];
            cycle(1, 0);
        end
        nxt_bricks = m_bricks;
        cycle(1, 0);

        // Reset in the middle of the lost countdown
        set_play(1);
        cycle(1, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0);
        rst_n = 1'b0;
        cycle(1, 1);
        rst_n = 1'b1;
        cycle(0, 0);
        cycle(1, 0);

        @(posedge clk);
        #3;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain got %0d pending entries want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
